// File: rtl/vga_sched_pkg.sv
// vga_sched_pkg: shared state encoding and raster defaults for vga_read_scheduler.
package vga_sched_pkg;
    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_ARMED   = 2'd1,
        ST_STREAM  = 2'd2,
        ST_RESYNC  = 2'd3
    } sched_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int X_START_DEF  = 1;

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
    endfunction
endpackage

// File: rtl/vga_test_pattern.sv
// vga_test_pattern: 64-pixel-wide eight-colour bars derived from the raster column.
module vga_test_pattern
    import vga_sched_pkg::*;
#(
    parameter int COORD_W = 12,
    parameter int X_START = X_START_DEF
) (
    input  logic [COORD_W-1:0] pixel_x,
    output logic [11:0]        rgb
);
    logic [COORD_W-1:0] offs;

    always_comb begin
        offs = pixel_x - COORD_W'(X_START);
        rgb  = bar_colour(3'(offs >> 6));
    end
endmodule

// File: rtl/vga_read_scheduler.sv
// vga_read_scheduler: paces async-FIFO pixel reads against the VGA raster, with underflow resync.
// Optional VGA_SCHED_TEST_PATTERN_EN shows colour bars while not streaming.
module vga_read_scheduler
    import vga_sched_pkg::*;
#(
    parameter int H_ACTIVE       = H_ACTIVE_DEF,
    parameter int V_ACTIVE       = V_ACTIVE_DEF,
    parameter int X_START        = X_START_DEF,
    parameter int STARTUP_FRAMES = 1,
    parameter int COORD_W        = 12,
    parameter int UFLOW_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               fifo_empty,
    input  logic [11:0]        fifo_din,
    output logic               fifo_rd_en,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               streaming,
    output logic [UFLOW_W-1:0] underflow_cnt
);
    sched_state_e       state_q, state_d;
    logic [3:0]         frame_cnt_q, frame_cnt_d;
    logic [UFLOW_W-1:0] ucnt_q, ucnt_d;
    logic [11:0]        rgb_q, rgb_d;
    logic               hs_q, vs_q, streaming_q, streaming_d;
    logic               active, frame_tick, first_px, vblank_start, rd_en;
    logic [11:0]        idle_rgb;

`ifdef VGA_SCHED_TEST_PATTERN_EN
    logic [11:0] pattern_rgb;

    vga_test_pattern #(.COORD_W(COORD_W), .X_START(X_START)) u_pattern (
        .pixel_x (pixel_x),
        .rgb     (pattern_rgb)
    );

    assign idle_rgb = active ? pattern_rgb : 12'h000;
`else
    assign idle_rgb = 12'h000;
`endif

    always_comb begin
        active       = pixel_x >= COORD_W'(X_START) && pixel_x <= COORD_W'(X_START + H_ACTIVE - 1) &&
                       pixel_y < COORD_W'(V_ACTIVE);
        frame_tick   = pixel_x == '0 && pixel_y == '0;
        first_px     = pixel_x == COORD_W'(X_START) && pixel_y == '0;
        vblank_start = pixel_x == '0 && pixel_y == COORD_W'(V_ACTIVE);
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        ucnt_d      = ucnt_q;
        rd_en       = 1'b0;
        rgb_d       = idle_rgb;
        case (state_q)
            ST_STARTUP: begin
                if (frame_cnt_q >= 4'(STARTUP_FRAMES))
                    state_d = ST_ARMED;
                else if (frame_tick)
                    frame_cnt_d = frame_cnt_q + 4'd1;
            end
            ST_ARMED: begin
                if (first_px && !fifo_empty) begin
                    rd_en   = 1'b1;
                    rgb_d   = fifo_din;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                rgb_d = 12'h000;
                if (active && !fifo_empty) begin
                    rd_en = 1'b1;
                    rgb_d = fifo_din;
                end else if (active) begin
                    ucnt_d  = &ucnt_q ? ucnt_q : ucnt_q + UFLOW_W'(1);
                    state_d = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                rd_en = !fifo_empty;
                if (vblank_start)
                    state_d = ST_ARMED;
            end
        endcase
        streaming_d = state_d == ST_STREAM;
    end

    // Reset gates the pop directly since it must drop before the next clock edge.
    assign fifo_rd_en = rd_en && !fifo_empty && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STARTUP;
            frame_cnt_q <= 4'd0;
            ucnt_q      <= '0;
            rgb_q       <= 12'h000;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            streaming_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            ucnt_q      <= ucnt_d;
            rgb_q       <= rgb_d;
            hs_q        <= hsync_in;
            vs_q        <= vsync_in;
            streaming_q <= streaming_d;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb_q;
    assign vga_hs                = hs_q;
    assign vga_vs                = vs_q;
    assign streaming             = streaming_q;
    assign underflow_cnt         = ucnt_q;
endmodule
